exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception and interrupt controller for the single-cycle MIPS core. It gathers the synchronous exception flags from decode/ALU and the external interrupt lines, and picks one cause per cycle. It owns the CP0 Status/Cause/EPC registers and drives the program counter's redirect inputs: the exception request, the ERET request and the return target address.

## Interface
Parameters:
- EXC_VECTOR, 32'h00000800: handler entry address; informational, must match the PC block's exception address.
- NUM_IRQ, 6: number of hardware interrupt lines, range 1..6.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- irq  in  NUM_IRQ  level-sensitive interrupt lines.
- instr_valid  in  1  the current instruction is real; it gates every exception and ERET.
- pc  in  32  address of the current instruction.
- exc_ri  in  1  reserved/illegal instruction.
- exc_ov  in  1  arithmetic overflow.
- exc_sys  in  1  SYSCALL.
- eret  in  1  ERET decoded.
- mtc0_we  in  1  MTC0 write strobe.
- cp0_waddr  in  5  MTC0 register number.
- cp0_wdata  in  32  MTC0 data.
- cp0_raddr  in  5  MFC0 register number.
- cp0_rdata  out  32  MFC0 data, combinational.
- has_exp  out  1  redirect to EXC_VECTOR this cycle; suppresses the instruction's register/memory commit.
- eret_taken  out  1  redirect to EPC this cycle.
- cp0_target_addr  out  32  current EPC.
- exl  out  1  Status.EXL.

## Operation
- Registers:
  - Status (12): bit0 IE, bit1 EXL, bits[9+NUM_IRQ:10] IM.
  - Cause (13): bits[6:2] ExcCode, bits[9+NUM_IRQ:10] IP (read-only, mirrors the ip register).
  - EPC (14): 32 bits.
  - Unlisted bits read 0. Other register numbers read 0; writes to them are ignored.
- ip register: samples irq every clock.
- Interrupt request: int_req = IE & ~EXL & |(ip & IM).
- Cause selection when instr_valid, fixed priority:
  - Interrupt (ExcCode 0) > RI (10) > Ov (12) > Sys (8).
  - Interrupts are considered only when int_req is set.
- On a taken cause:
  - has_exp=1.
  - Cause.ExcCode is updated.
  - If EXL was 0: EPC<=pc and EXL<=1.
  - If EXL was already 1 (synchronous exception inside the handler): EPC and EXL are unchanged and has_exp is still 1.
- ERET: when instr_valid & eret & EXL & ~has_exp, then eret_taken=1 and EXL<=0. ERET with EXL=0 is a no-op: no redirect, no state change.
- MTC0: writes the addressed register at the clock edge. If has_exp is 1 in the same cycle, the write is discarded.
- Simultaneous events:
  - Exception beats ERET on the same instruction.
  - An interrupt pending while ERET executes is taken no earlier than the next instruction, because EXL is still 1 during the ERET cycle.
  - Several sync flags at once: only the highest-priority cause is recorded.
- Reset: Status, Cause, EPC and ip all clear. Outputs at reset: has_exp=0, eret_taken=0, cp0_target_addr=0, exl=0, cp0_rdata=0.

## Timing
- has_exp, eret_taken, cp0_target_addr and cp0_rdata are combinational from the current state and inputs, in the same cycle as the instruction.
- All register updates occur at the posedge that ends that cycle.
- MFC0 in the cycle of an MTC0 returns the old value. The new value is visible from the next cycle.
- Interrupt latency without the synchronizer: irq high before edge N sets ip at N, and has_exp can assert in cycle N+1.
- With the synchronizer: has_exp can assert no earlier than cycle N+3.
- Deasserting irq clears IP with the same latency as assertion. There is no latching beyond ip.
- Asynchronous reset mid-handler forces EXL=0 and EPC=0 immediately, independent of clk.

## Configuration
- EXC_IRQ_SYNC_EN defined: irq passes through a 2-flop synchronizer before ip, adding 2 cycles of interrupt latency. Use this when irq sources are asynchronous to clk.
- Not defined: irq feeds ip directly and must already be synchronous to clk.

## Test plan
- Reset release, then ERET with EXL=0 -> eret_taken=0 and all CP0 reads return 0.
- pc=0x00000040 with exc_ov=1 -> has_exp=1 that cycle; next cycle EPC=0x40, ExcCode=12, EXL=1.
- RI and SYSCALL together at pc=0x100 -> ExcCode=10; then ERET -> eret_taken=1, cp0_target_addr=0x100, EXL=0 next cycle.
- Status written to 0x00000401 (IE=1, IM bit0=1), then irq[0]=1 -> has_exp asserts 1 cycle later without the macro and 3 cycles later with it; ExcCode=0 and IP bit10=1.
- With EXL=1: irq asserted -> no exception. exc_sys=1 at pc=0x200 -> has_exp=1, EPC unchanged.
- MTC0 to EPC in the same cycle as exc_ri -> write discarded and EPC=pc; rst_n pulsed low mid-handler -> exl=0 without a clock edge.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception and interrupt controller for the single-cycle MIPS core.
// Owns CP0 Status (12), Cause (13) and EPC (14), picks one exception cause per
// instruction and drives the PC redirect requests (exception entry / ERET).
// Optional feature macro: EXC_IRQ_SYNC_EN puts a 2-flop synchronizer in front
// of the ip register for irq lines that are asynchronous to clk.

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000800,
  parameter int          NUM_IRQ    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               instr_valid,
  input  logic [31:0]        pc,
  input  logic               exc_ri,
  input  logic               exc_ov,
  input  logic               exc_sys,
  input  logic               eret,
  input  logic               mtc0_we,
  input  logic [4:0]         cp0_waddr,
  input  logic [31:0]        cp0_wdata,
  input  logic [4:0]         cp0_raddr,
  output logic [31:0]        cp0_rdata,
  output logic               has_exp,
  output logic               eret_taken,
  output logic [31:0]        cp0_target_addr,
  output logic               exl
);

  // CP0 register numbers
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // The handler address lives in the PC block; it only has to be word aligned.
  if (EXC_VECTOR[1:0] != 2'b00) begin : g_vector_unaligned
  end

  // CP0 state
  logic               ie_r;
  logic               exl_r;
  logic [NUM_IRQ-1:0] im_r;
  logic [NUM_IRQ-1:0] ip_r;
  logic [4:0]         exc_code_r;
  logic [31:0]        epc_r;

  // Interrupt source feeding ip
  logic [NUM_IRQ-1:0] irq_src_s;

`ifdef EXC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta_r;
  logic [NUM_IRQ-1:0] irq_sync_r;

  // Two-flop synchronizer for irq lines coming from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_r <= {NUM_IRQ{1'b0}};
      irq_sync_r <= {NUM_IRQ{1'b0}};
    end else begin
      irq_meta_r <= irq;
      irq_sync_r <= irq_meta_r;
    end
  end

  assign irq_src_s = irq_sync_r;
`else
  assign irq_src_s = irq;
`endif

  // Combinational decisions for the current instruction
  logic        int_req_s;
  logic        take_s;
  logic [4:0]  code_s;
  logic        eret_ok_s;
  logic [31:0] status_s;
  logic [31:0] cause_s;

  // An interrupt is only requested outside the handler with its line unmasked
  assign int_req_s = ie_r & ~exl_r & (|(ip_r & im_r));

  // Fixed-priority cause selection: interrupt > RI > Ov > Sys
  always_comb begin
    take_s = 1'b0;
    code_s = EXC_INT;
    if (instr_valid) begin
      if (int_req_s) begin
        take_s = 1'b1;
        code_s = EXC_INT;
      end else if (exc_ri) begin
        take_s = 1'b1;
        code_s = EXC_RI;
      end else if (exc_ov) begin
        take_s = 1'b1;
        code_s = EXC_OV;
      end else if (exc_sys) begin
        take_s = 1'b1;
        code_s = EXC_SYS;
      end else begin
        take_s = 1'b0;
        code_s = EXC_INT;
      end
    end else begin
      take_s = 1'b0;
      code_s = EXC_INT;
    end
  end

  // ERET only returns from inside the handler and loses to any exception
  assign eret_ok_s = instr_valid & eret & exl_r & ~take_s;

  // Assemble the readable images of Status and Cause; unlisted bits read 0
  always_comb begin
    status_s                = 32'h00000000;
    status_s[0]             = ie_r;
    status_s[1]             = exl_r;
    status_s[10 +: NUM_IRQ] = im_r;
    cause_s                 = 32'h00000000;
    cause_s[6:2]            = exc_code_r;
    cause_s[10 +: NUM_IRQ]  = ip_r;
  end

  // MFC0 read mux; returns the pre-edge value during an MTC0 cycle
  always_comb begin
    cp0_rdata = 32'h00000000;
    case (cp0_raddr)
      REG_STATUS: cp0_rdata = status_s;
      REG_CAUSE:  cp0_rdata = cause_s;
      REG_EPC:    cp0_rdata = epc_r;
      default:    cp0_rdata = 32'h00000000;
    endcase
  end

  // ip simply follows the (optionally synchronized) irq lines, no latching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_r <= {NUM_IRQ{1'b0}};
    end else begin
      ip_r <= irq_src_s;
    end
  end

  // CP0 state update: exception entry, MTC0 and ERET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_r       <= 1'b0;
      exl_r      <= 1'b0;
      im_r       <= {NUM_IRQ{1'b0}};
      exc_code_r <= 5'd0;
      epc_r      <= 32'h00000000;
    end else begin
      if (take_s) begin
        // A nested synchronous exception keeps the original return address
        exc_code_r <= code_s;
        if (!exl_r) begin
          epc_r <= pc;
          exl_r <= 1'b1;
        end
      end else begin
        // MTC0 is squashed along with the rest of a faulting instruction
        if (mtc0_we) begin
          case (cp0_waddr)
            REG_STATUS: begin
              ie_r  <= cp0_wdata[0];
              exl_r <= cp0_wdata[1];
              im_r  <= cp0_wdata[10 +: NUM_IRQ];
            end
            REG_CAUSE: begin
              exc_code_r <= cp0_wdata[6:2];
            end
            REG_EPC: begin
              epc_r <= cp0_wdata;
            end
            default: begin
            end
          endcase
        end
        if (eret_ok_s) begin
          exl_r <= 1'b0;
        end
      end
    end
  end

  assign has_exp         = take_s;
  assign eret_taken      = eret_ok_s;
  assign cp0_target_addr = epc_r;
  assign exl             = exl_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed testbench for exc_ctrl. Inputs change on the falling edge and
// outputs are checked shortly afterwards, well away from the rising edge.

module tb_exc_ctrl;

  localparam int NUM_IRQ = 6;
`ifdef EXC_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq;
  logic               instr_valid;
  logic [31:0]        pc;
  logic               exc_ri;
  logic               exc_ov;
  logic               exc_sys;
  logic               eret;
  logic               mtc0_we;
  logic [4:0]         cp0_waddr;
  logic [31:0]        cp0_wdata;
  logic [4:0]         cp0_raddr;
  logic [31:0]        cp0_rdata;
  logic               has_exp;
  logic               eret_taken;
  logic [31:0]        cp0_target_addr;
  logic               exl;

  int vectors     = 0;
  int miscompares = 0;

  exc_ctrl #(
    .EXC_VECTOR (32'h00000800),
    .NUM_IRQ    (NUM_IRQ)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq             (irq),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .exc_ri          (exc_ri),
    .exc_ov          (exc_ov),
    .exc_sys         (exc_sys),
    .eret            (eret),
    .mtc0_we         (mtc0_we),
    .cp0_waddr       (cp0_waddr),
    .cp0_wdata       (cp0_wdata),
    .cp0_raddr       (cp0_raddr),
    .cp0_rdata       (cp0_rdata),
    .has_exp         (has_exp),
    .eret_taken      (eret_taken),
    .cp0_target_addr (cp0_target_addr),
    .exl             (exl)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    cp0_raddr = addr;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  // Move to the next falling edge and return all instruction inputs to idle
  task automatic nxt();
    @(negedge clk);
    instr_valid = 1'b0;
    pc          = 32'h00000000;
    exc_ri      = 1'b0;
    exc_ov      = 1'b0;
    exc_sys     = 1'b0;
    eret        = 1'b0;
    mtc0_we     = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'h00000000;
  endtask

  initial begin
    rst_n       = 1'b0;
    irq         = '0;
    instr_valid = 1'b0;
    pc          = 32'h00000000;
    exc_ri      = 1'b0;
    exc_ov      = 1'b0;
    exc_sys     = 1'b0;
    eret        = 1'b0;
    mtc0_we     = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'h00000000;
    cp0_raddr   = 5'd12;

    // Reset values
    #5;
    chk("rst_has_exp", 32'(has_exp), 32'd0);
    chk("rst_eret_taken", 32'(eret_taken), 32'd0);
    chk("rst_target", cp0_target_addr, 32'h00000000);
    chk("rst_exl", 32'(exl), 32'd0);
    chk("rst_rdata", cp0_rdata, 32'h00000000);

    // ERET with EXL=0 is a no-op; all CP0 reads return 0
    nxt();
    rst_n = 1'b1;
    instr_valid = 1'b1; eret = 1'b1;
    #1;
    chk("eret_noexl_taken", 32'(eret_taken), 32'd0);
    chk("eret_noexl_exp", 32'(has_exp), 32'd0);
    rd(5'd12, "rd_status0", 32'h00000000);
    rd(5'd13, "rd_cause0", 32'h00000000);
    rd(5'd14, "rd_epc0", 32'h00000000);
    nxt();
    #1;
    chk("eret_noexl_exl", 32'(exl), 32'd0);

    // Overflow at 0x40
    nxt();
    instr_valid = 1'b1; pc = 32'h00000040; exc_ov = 1'b1;
    #1;
    chk("ov_has_exp", 32'(has_exp), 32'd1);
    nxt();
    #1;
    chk("ov_exl", 32'(exl), 32'd1);
    chk("ov_target", cp0_target_addr, 32'h00000040);
    rd(5'd14, "ov_epc", 32'h00000040);
    rd(5'd13, "ov_cause", 32'h00000030);

    // Return from the overflow handler
    nxt();
    instr_valid = 1'b1; eret = 1'b1;
    #1;
    chk("eret1_taken", 32'(eret_taken), 32'd1);
    chk("eret1_target", cp0_target_addr, 32'h00000040);
    nxt();
    #1;
    chk("eret1_exl", 32'(exl), 32'd0);

    // RI and SYSCALL together: RI wins
    nxt();
    instr_valid = 1'b1; pc = 32'h00000100; exc_ri = 1'b1; exc_sys = 1'b1;
    #1;
    chk("ri_has_exp", 32'(has_exp), 32'd1);
    nxt();
    rd(5'd13, "ri_cause", 32'h00000028);
    rd(5'd14, "ri_epc", 32'h00000100);

    // Exception beats ERET; nested: EPC unchanged, ExcCode updated
    nxt();
    instr_valid = 1'b1; pc = 32'h00000180; eret = 1'b1; exc_ov = 1'b1;
    #1;
    chk("exc_vs_eret_exp", 32'(has_exp), 32'd1);
    chk("exc_vs_eret_taken", 32'(eret_taken), 32'd0);
    nxt();
    rd(5'd13, "nest_cause", 32'h00000030);
    rd(5'd14, "nest_epc", 32'h00000100);

    // ERET back to 0x100
    nxt();
    instr_valid = 1'b1; eret = 1'b1;
    #1;
    chk("eret2_taken", 32'(eret_taken), 32'd1);
    chk("eret2_target", cp0_target_addr, 32'h00000100);
    nxt();
    #1;
    chk("eret2_exl", 32'(exl), 32'd0);

    // MTC0 Status=0x401; same-cycle read returns the old value
    nxt();
    instr_valid = 1'b1; mtc0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h00000401;
    rd(5'd12, "mtc0_old", 32'h00000000);
    nxt();
    rd(5'd12, "mtc0_new", 32'h00000401);

    // irq[0] raised; interrupt taken IRQ_LAT cycles later
    nxt();
    instr_valid = 1'b1; pc = 32'h000002F0; irq = 6'b000001;
    #1;
    chk("irq_lat0", 32'(has_exp), 32'd0);
    for (int k = 1; k <= IRQ_LAT; k++) begin
      nxt();
      instr_valid = 1'b1; pc = 32'h00000300;
      #1;
      chk($sformatf("irq_lat%0d", k), 32'(has_exp), (k == IRQ_LAT) ? 32'd1 : 32'd0);
    end
    nxt();
    #1;
    chk("irq_exl", 32'(exl), 32'd1);
    rd(5'd13, "irq_cause", 32'h00000400);
    rd(5'd14, "irq_epc", 32'h00000300);

    // Inside the handler: pending irq ignored, SYSCALL still raises has_exp
    nxt();
    instr_valid = 1'b1; pc = 32'h00000310;
    #1;
    chk("exl_irq_masked", 32'(has_exp), 32'd0);
    nxt();
    instr_valid = 1'b1; pc = 32'h00000200; exc_sys = 1'b1;
    #1;
    chk("sys_in_handler", 32'(has_exp), 32'd1);
    nxt();
    rd(5'd14, "sys_epc_kept", 32'h00000300);
    rd(5'd13, "sys_cause", 32'h00000420);

    // Drop irq and leave the handler, then let ip drain
    nxt();
    irq = 6'b000000;
    instr_valid = 1'b1; eret = 1'b1;
    #1;
    chk("eret3_taken", 32'(eret_taken), 32'd1);
    for (int k = 0; k < IRQ_LAT; k++) begin
      nxt();
    end
    #1;
    chk("eret3_exl", 32'(exl), 32'd0);
    rd(5'd13, "ip_cleared", 32'h00000020);

    // MTC0 to EPC alongside RI: write discarded, EPC = pc
    nxt();
    instr_valid = 1'b1; pc = 32'h00000500; exc_ri = 1'b1;
    mtc0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD0000;
    #1;
    chk("mtc0_ri_exp", 32'(has_exp), 32'd1);
    nxt();
    #1;
    chk("mtc0_ri_exl", 32'(exl), 32'd1);
    rd(5'd14, "mtc0_ri_epc", 32'h00000500);
    rd(5'd13, "mtc0_ri_cause", 32'h00000028);

    // Asynchronous reset mid-cycle clears the handler state without a clock edge
    nxt();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_exl", 32'(exl), 32'd0);
    chk("arst_target", cp0_target_addr, 32'h00000000);
    rd(5'd12, "arst_status", 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
